sync_counter_ctrl: RTL and testbench

- AXI-domain measurement sequencer that sits directly downstream and upstream of the dual-enable synchronous counter.
- Drives the counter's `reset` and `snapshot` inputs through a timed clear / run / freeze sequence.
- Accepts a gate window length in axi_clk cycles, waits for the frozen tclk counts to settle across the CDC, and captures counts once they are verified stable.
- Presents latched results with a valid flag and a done pulse, for register readout by the Caribou AXI slave.

---
 rtl/sync_counter_pkg.sv | 37 +++
 rtl/sync_counter_ctrl_if.sv | 24 ++
 rtl/sync_counter_ctrl_cycle_timer.sv | 38 +++
 rtl/sync_counter_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_sync_counter_ctrl.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sync_counter_pkg.sv
// Shared types and constants for the counter measurement sequencer.
// The state encoding and timing minimums are used by the controller and its checks.
package sync_counter_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        ARM     = 3'd2,
        RUN     = 3'd3,
        FREEZE  = 3'd4,
        CAPTURE = 3'd5,
        DONE    = 3'd6
    } ctrl_state_t;

    // Four axi_clk cycles are enough for reset/snapshot to cross into tclk and back.
    localparam int unsigned MIN_RESET_CYCLES  = 4;
    localparam int unsigned MIN_SETTLE_CYCLES = 4;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) begin
            m = b;
        end else begin
            m = m;
        end
        if (c > m) begin
            m = c;
        end else begin
            m = m;
        end
        return m;
    endfunction

endpackage

// File: rtl/sync_counter_ctrl_if.sv
// Link between the sequencer and the dual-enable counter: control out, results back.
interface sync_counter_ctrl_if #(
    parameter int unsigned COUNTER_A_BITS = 32,
    parameter int unsigned COUNTER_B_BITS = 32
);
    logic                      ctr_reset;
    logic                      ctr_snapshot;
    logic [COUNTER_A_BITS-1:0] counter_a_result;
    logic [COUNTER_B_BITS-1:0] counter_b_result;

    modport master (
        output ctr_reset,
        output ctr_snapshot,
        input  counter_a_result,
        input  counter_b_result
    );

    modport slave (
        input  ctr_reset,
        input  ctr_snapshot,
        output counter_a_result,
        output counter_b_result
    );
endinterface

// File: rtl/sync_counter_ctrl_cycle_timer.sv
// Loadable down-counter shared by all timed phases; zero marks the last cycle of a phase.
module cycle_timer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: load wins, otherwise count down and stick at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != {WIDTH{1'b0}}) begin
            count_d = count_q - WIDTH'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= {WIDTH{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == {WIDTH{1'b0}});

endmodule

// File: rtl/sync_counter_ctrl.sv
// Clear/run/freeze sequencer for the dual-enable counter; captures the frozen
// counts once two consecutive samples agree and presents them for readout.
module sync_counter_ctrl
    import sync_counter_pkg::*;
#(
    parameter int unsigned COUNTER_A_BITS = 32,
    parameter int unsigned COUNTER_B_BITS = 32,
    parameter int unsigned GATE_BITS      = 32,
    parameter int unsigned RESET_CYCLES   = 8,
    parameter int unsigned SETTLE_CYCLES  = 8,
    parameter int unsigned STABLE_TRIES   = 4
) (
    input  logic                      axi_clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      continuous,
    input  logic [GATE_BITS-1:0]      gate_cycles,
    sync_counter_ctrl_if.master       ctr,
    output logic [COUNTER_A_BITS-1:0] result_a,
    output logic [COUNTER_B_BITS-1:0] result_b,
    output logic                      result_valid,
    output logic                      result_stale,
    output logic                      busy,
    output logic                      done,
    output logic [15:0]               meas_count
);

    localparam int unsigned TIMER_W = max3(GATE_BITS, $clog2(RESET_CYCLES + 1),
                                           $clog2(SETTLE_CYCLES + 1));
    localparam int unsigned TRY_W   = $clog2(STABLE_TRIES + 1);

    localparam logic [TIMER_W-1:0] RESET_LOAD  = TIMER_W'(RESET_CYCLES - 1);
    localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(SETTLE_CYCLES - 1);
    localparam logic [TRY_W-1:0]   LAST_TRY    = TRY_W'(STABLE_TRIES - 1);

    generate
        if (RESET_CYCLES < MIN_RESET_CYCLES) begin : g_bad_reset_cycles
            $error("RESET_CYCLES below minimum");
        end
        if (SETTLE_CYCLES < MIN_SETTLE_CYCLES) begin : g_bad_settle_cycles
            $error("SETTLE_CYCLES below minimum");
        end
        if (STABLE_TRIES < 1) begin : g_bad_stable_tries
            $error("STABLE_TRIES must be at least 1");
        end
    endgenerate

    ctrl_state_t               state_q,        state_d;
    logic [GATE_BITS-1:0]      gate_q,         gate_d;
    logic [COUNTER_A_BITS-1:0] prev_a_q,       prev_a_d;
    logic [COUNTER_B_BITS-1:0] prev_b_q,       prev_b_d;
    logic                      first_q,        first_d;
    logic [TRY_W-1:0]          fail_q,         fail_d;
    logic [COUNTER_A_BITS-1:0] result_a_q,     result_a_d;
    logic [COUNTER_B_BITS-1:0] result_b_q,     result_b_d;
    logic                      valid_q,        valid_d;
    logic                      stale_q,        stale_d;
    logic                      done_q,         done_d;
    logic [15:0]               meas_count_q,   meas_count_d;
    logic                      ctr_reset_q,    ctr_reset_d;
    logic                      ctr_snapshot_q, ctr_snapshot_d;
    logic                      busy_q,         busy_d;

    logic                      timer_load_s;
    logic [TIMER_W-1:0]        timer_val_s;
    logic                      timer_zero_s;
    logic [GATE_BITS-1:0]      gate_eff_s;
    logic                      match_s;

    cycle_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clk      (axi_clk),
        .reset    (reset),
        .load     (timer_load_s),
        .load_val (timer_val_s),
        .zero     (timer_zero_s)
    );

    // Sequencer next state, capture bookkeeping and next values of every registered output.
    always_comb begin
        state_d      = state_q;
        gate_d       = gate_q;
        prev_a_d     = prev_a_q;
        prev_b_d     = prev_b_q;
        first_d      = first_q;
        fail_d       = fail_q;
        result_a_d   = result_a_q;
        result_b_d   = result_b_q;
        valid_d      = valid_q;
        stale_d      = stale_q;
        done_d       = 1'b0;
        meas_count_d = meas_count_q;
        timer_load_s = 1'b0;
        timer_val_s  = {TIMER_W{1'b0}};
        gate_eff_s   = (gate_cycles == {GATE_BITS{1'b0}}) ? GATE_BITS'(1) : gate_cycles;
        match_s      = (ctr.counter_a_result == prev_a_q) && (ctr.counter_b_result == prev_b_q);

        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d      = CLEAR;
                        gate_d       = gate_eff_s;
                        timer_load_s = 1'b1;
                        timer_val_s  = RESET_LOAD;
                        valid_d      = 1'b0;
                        stale_d      = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                CLEAR: begin
                    if (timer_zero_s) begin
                        state_d      = ARM;
                        timer_load_s = 1'b1;
                        timer_val_s  = SETTLE_LOAD;
                    end else begin
                        state_d = CLEAR;
                    end
                end
                ARM: begin
                    if (timer_zero_s) begin
                        state_d      = RUN;
                        timer_load_s = 1'b1;
                        timer_val_s  = TIMER_W'(gate_q) - TIMER_W'(1);
                    end else begin
                        state_d = ARM;
                    end
                end
                RUN: begin
                    if (timer_zero_s) begin
                        state_d      = FREEZE;
                        timer_load_s = 1'b1;
                        timer_val_s  = SETTLE_LOAD;
                    end else begin
                        state_d = RUN;
                    end
                end
                FREEZE: begin
                    if (timer_zero_s) begin
                        state_d = CAPTURE;
                        first_d = 1'b1;
                        fail_d  = {TRY_W{1'b0}};
                    end else begin
                        state_d = FREEZE;
                    end
                end
                CAPTURE: begin
                    // Results are only ever written here, with the sample that closed the check.
                    prev_a_d = ctr.counter_a_result;
                    prev_b_d = ctr.counter_b_result;
                    if (first_q) begin
                        first_d = 1'b0;
                    end else if (match_s || (fail_q == LAST_TRY)) begin
                        state_d      = DONE;
                        result_a_d   = ctr.counter_a_result;
                        result_b_d   = ctr.counter_b_result;
                        valid_d      = 1'b1;
                        stale_d      = !match_s;
                        done_d       = 1'b1;
                        meas_count_d = meas_count_q + 16'd1;
                    end else begin
                        fail_d = fail_q + TRY_W'(1);
                    end
                end
                DONE: begin
                    if (continuous) begin
                        state_d      = CLEAR;
                        gate_d       = gate_eff_s;
                        timer_load_s = 1'b1;
                        timer_val_s  = RESET_LOAD;
                        valid_d      = 1'b0;
                        stale_d      = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        ctr_reset_d    = (state_d == CLEAR);
        ctr_snapshot_d = (state_d != RUN);
        busy_d         = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge axi_clk) begin
        if (reset) begin
            state_q        <= IDLE;
            gate_q         <= GATE_BITS'(1);
            prev_a_q       <= {COUNTER_A_BITS{1'b0}};
            prev_b_q       <= {COUNTER_B_BITS{1'b0}};
            first_q        <= 1'b0;
            fail_q         <= {TRY_W{1'b0}};
            result_a_q     <= {COUNTER_A_BITS{1'b0}};
            result_b_q     <= {COUNTER_B_BITS{1'b0}};
            valid_q        <= 1'b0;
            stale_q        <= 1'b0;
            done_q         <= 1'b0;
            meas_count_q   <= 16'd0;
            ctr_reset_q    <= 1'b0;
            ctr_snapshot_q <= 1'b1;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            gate_q         <= gate_d;
            prev_a_q       <= prev_a_d;
            prev_b_q       <= prev_b_d;
            first_q        <= first_d;
            fail_q         <= fail_d;
            result_a_q     <= result_a_d;
            result_b_q     <= result_b_d;
            valid_q        <= valid_d;
            stale_q        <= stale_d;
            done_q         <= done_d;
            meas_count_q   <= meas_count_d;
            ctr_reset_q    <= ctr_reset_d;
            ctr_snapshot_q <= ctr_snapshot_d;
            busy_q         <= busy_d;
        end
    end

    assign ctr.ctr_reset    = ctr_reset_q;
    assign ctr.ctr_snapshot = ctr_snapshot_q;
    assign result_a         = result_a_q;
    assign result_b         = result_b_q;
    assign result_valid     = valid_q;
    assign result_stale     = stale_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign meas_count       = meas_count_q;

endmodule

// File: tb/tb_sync_counter_ctrl.sv
// Directed bench for sync_counter_ctrl with default parameters (R=8, S=8, 4 tries).
module tb_sync_counter_ctrl;

    logic        axi_clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic        continuous;
    logic [31:0] gate_cycles;
    logic [31:0] result_a;
    logic [31:0] result_b;
    logic        result_valid;
    logic        result_stale;
    logic        busy;
    logic        done;
    logic [15:0] meas_count;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc;
    int          rst_hi;
    int          snap_lo;
    int          n_done;
    logic [31:0] last_a;
    logic [31:0] last_b;
    logic [31:0] held_a;

    always #5 axi_clk = ~axi_clk;

    sync_counter_ctrl_if #(.COUNTER_A_BITS(32), .COUNTER_B_BITS(32)) ctr_if ();

    sync_counter_ctrl dut (
        .axi_clk      (axi_clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .continuous   (continuous),
        .gate_cycles  (gate_cycles),
        .ctr          (ctr_if.master),
        .result_a     (result_a),
        .result_b     (result_b),
        .result_valid (result_valid),
        .result_stale (result_stale),
        .busy         (busy),
        .done         (done),
        .meas_count   (meas_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge axi_clk);
        @(negedge axi_clk);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_ctr_reset"}, 32'(ctr_if.ctr_reset), 32'd0);
        check_eq({tag, "_ctr_snapshot"}, 32'(ctr_if.ctr_snapshot), 32'd1);
        check_eq({tag, "_result_a"}, result_a, 32'd0);
        check_eq({tag, "_result_b"}, result_b, 32'd0);
        check_eq({tag, "_valid"}, 32'(result_valid), 32'd0);
        check_eq({tag, "_stale"}, 32'(result_stale), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_done"}, 32'(done), 32'd0);
        check_eq({tag, "_meas"}, 32'(meas_count), 32'd0);
    endtask

    // Steps until done is seen (or the budget runs out); cycle count continues from start_cyc.
    task automatic wait_done(input string tag, input int start_cyc, input int max_cyc,
                             input bit tog, output int c, output int rh, output int sl);
        c  = start_cyc;
        rh = 0;
        sl = 0;
        while (c < max_cyc) begin
            if (tog) begin
                ctr_if.counter_a_result = ctr_if.counter_a_result ^ 32'h0000_00FF;
                ctr_if.counter_b_result = ctr_if.counter_b_result ^ 32'h0000_000F;
            end
            last_a = ctr_if.counter_a_result;
            last_b = ctr_if.counter_b_result;
            step();
            start = 1'b0;
            c++;
            if (ctr_if.ctr_reset) rh++;
            if (!ctr_if.ctr_snapshot) sl++;
            if (done) break;
        end
        check_eq({tag, "_done_seen"}, 32'(done), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        continuous  = 1'b0;
        gate_cycles = 32'd100;
        ctr_if.counter_a_result = 32'h64;
        ctr_if.counter_b_result = 32'h32;
        repeat (3) step();
        reset = 1'b0;
        step();
        check_reset_state("rst");

        // Basic measurement: done lands in cycle 127 after the start cycle.
        start = 1'b1;
        wait_done("t1", 0, 300, 1'b0, cyc, rst_hi, snap_lo);
        check_eq("t1_latency", 32'(cyc), 32'd127);
        check_eq("t1_reset_len", 32'(rst_hi), 32'd8);
        check_eq("t1_run_len", 32'(snap_lo), 32'd100);
        check_eq("t1_result_a", result_a, 32'h64);
        check_eq("t1_result_b", result_b, 32'h32);
        check_eq("t1_valid", 32'(result_valid), 32'd1);
        check_eq("t1_stale", 32'(result_stale), 32'd0);
        check_eq("t1_meas", 32'(meas_count), 32'd1);
        step();
        check_eq("t1_done_pulse", 32'(done), 32'd0);
        check_eq("t1_busy_after", 32'(busy), 32'd0);

        // Unstable inputs: four failed compares then a stale capture of the last sample.
        gate_cycles = 32'd5;
        start = 1'b1;
        step();
        start = 1'b0;
        check_eq("t2_valid_cleared", 32'(result_valid), 32'd0);
        check_eq("t2_result_held", result_a, 32'h64);
        wait_done("t2", 1, 300, 1'b1, cyc, rst_hi, snap_lo);
        check_eq("t2_latency", 32'(cyc), 32'd35);
        check_eq("t2_result_a", result_a, last_a);
        check_eq("t2_result_b", result_b, last_b);
        check_eq("t2_valid", 32'(result_valid), 32'd1);
        check_eq("t2_stale", 32'(result_stale), 32'd1);
        check_eq("t2_meas", 32'(meas_count), 32'd2);
        held_a = last_a;
        ctr_if.counter_a_result = 32'h10;
        ctr_if.counter_b_result = 32'h20;
        step();

        // Abort during RUN, then a clean rerun.
        gate_cycles = 32'd50;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (39) step();
        check_eq("t3_in_run", 32'(ctr_if.ctr_snapshot), 32'd0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_eq("t3_busy", 32'(busy), 32'd0);
        check_eq("t3_snapshot", 32'(ctr_if.ctr_snapshot), 32'd1);
        check_eq("t3_ctr_reset", 32'(ctr_if.ctr_reset), 32'd0);
        check_eq("t3_meas", 32'(meas_count), 32'd2);
        check_eq("t3_result_held", result_a, held_a);
        check_eq("t3_valid", 32'(result_valid), 32'd0);
        n_done = 0;
        for (int i = 0; i < 100; i++) begin
            if (done) n_done++;
            step();
        end
        check_eq("t3_no_done", 32'(n_done), 32'd0);
        start = 1'b1;
        wait_done("t3r", 0, 300, 1'b0, cyc, rst_hi, snap_lo);
        check_eq("t3r_latency", 32'(cyc), 32'd77);
        check_eq("t3r_result_a", result_a, 32'h10);
        check_eq("t3r_result_b", result_b, 32'h20);
        check_eq("t3r_stale", 32'(result_stale), 32'd0);
        check_eq("t3r_meas", 32'(meas_count), 32'd3);
        step();

        // gate_cycles=0 runs one cycle; a second start while busy is ignored.
        gate_cycles = 32'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        start = 1'b1;
        wait_done("t4", 4, 300, 1'b0, cyc, rst_hi, snap_lo);
        check_eq("t4_latency", 32'(cyc), 32'd28);
        check_eq("t4_run_len", 32'(snap_lo), 32'd1);
        check_eq("t4_meas", 32'(meas_count), 32'd4);
        step();
        step();
        check_eq("t4_idle", 32'(busy), 32'd0);

        // start together with abort in IDLE stays IDLE.
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        check_eq("t5_busy", 32'(busy), 32'd0);
        check_eq("t5_ctr_reset", 32'(ctr_if.ctr_reset), 32'd0);
        step();
        check_eq("t5_busy_later", 32'(busy), 32'd0);

        // Continuous mode: 37-cycle loop; a mid-run gate change applies from the next loop.
        gate_cycles = 32'd10;
        continuous  = 1'b1;
        start = 1'b1;
        wait_done("t6a", 0, 200, 1'b0, cyc, rst_hi, snap_lo);
        check_eq("t6a_latency", 32'(cyc), 32'd37);
        check_eq("t6a_meas", 32'(meas_count), 32'd5);
        wait_done("t6b", 0, 200, 1'b0, cyc, rst_hi, snap_lo);
        check_eq("t6b_spacing", 32'(cyc), 32'd37);
        check_eq("t6b_reset_len", 32'(rst_hi), 32'd8);
        check_eq("t6b_meas", 32'(meas_count), 32'd6);
        repeat (20) step();
        gate_cycles = 32'd20;
        wait_done("t6c", 20, 200, 1'b0, cyc, rst_hi, snap_lo);
        check_eq("t6c_spacing", 32'(cyc), 32'd37);
        check_eq("t6c_meas", 32'(meas_count), 32'd7);
        step();
        continuous = 1'b0;
        wait_done("t6d", 1, 200, 1'b0, cyc, rst_hi, snap_lo);
        check_eq("t6d_spacing", 32'(cyc), 32'd47);
        check_eq("t6d_meas", 32'(meas_count), 32'd8);
        step();
        check_eq("t6_idle", 32'(busy), 32'd0);

        // meas_count wraps from 0xFFFF to 0.
        force dut.meas_count_q = 16'hFFFF;
        step();
        release dut.meas_count_q;
        step();
        check_eq("t7_preset", 32'(meas_count), 32'h0000_FFFF);
        gate_cycles = 32'd1;
        start = 1'b1;
        wait_done("t7", 0, 200, 1'b0, cyc, rst_hi, snap_lo);
        check_eq("t7_wrap", 32'(meas_count), 32'd0);
        check_eq("t7_valid", 32'(result_valid), 32'd1);
        step();

        // Reset in FREEZE returns every output to its reset value.
        gate_cycles = 32'd5;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (24) step();
        check_eq("t8_busy", 32'(busy), 32'd1);
        check_eq("t8_frozen", 32'(ctr_if.ctr_snapshot), 32'd1);
        reset = 1'b1;
        step();
        check_reset_state("t8");
        reset = 1'b0;
        step();
        check_eq("t8_busy_after", 32'(busy), 32'd0);
        check_eq("t8_done_after", 32'(done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
